uart_cmd_framer: RTL and testbench

- Sits between the UART receiver and the task state machine.
- Assembles the received byte stream into one command: a 2-bit opcode plus two 32-bit IEEE-754 operands, A and B.
- Presents the command on a valid/ready handshake.
- Rejects illegal opcodes and stalled frames so the task state machine only ever sees complete, legal commands.

---
 rtl/uart_cmd_framer.sv | 205 ++++++++++++++++++++
 tb/tb_uart_cmd_framer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_framer.sv
// Assembles UART bytes into {opcode, A, B} commands presented on a valid/ready handshake.
// Optional trailing XOR checksum byte is enabled by defining CMD_CHECKSUM_EN.
module uart_cmd_framer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_BITS       = 24
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  input  logic        cmd_ready,
  output logic        cmd_valid,
  output logic [1:0]  cmd_opcode,
  output logic [31:0] cmd_a,
  output logic [31:0] cmd_b,
  output logic        busy,
  output logic        err_opcode,
  output logic        err_timeout,
  output logic        err_overrun,
  output logic        err_checksum
);

  localparam logic [2:0] S_OPCODE = 3'd0;
  localparam logic [2:0] S_A      = 3'd1;
  localparam logic [2:0] S_B      = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd4;
`ifdef CMD_CHECKSUM_EN
  localparam logic [2:0] S_CSUM   = 3'd3;
`endif
  localparam logic [CNT_BITS-1:0] IDLE_LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);

  logic [2:0]          state_q, state_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [31:0]         shift_q, shift_d, shift_next;
  logic [31:0]         a_pend_q, a_pend_d;
  logic [1:0]          op_pend_q, op_pend_d;
  logic [CNT_BITS-1:0] idle_q, idle_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic [1:0]          cmd_opcode_q, cmd_opcode_d;
  logic [31:0]         cmd_a_q, cmd_a_d, cmd_b_q, cmd_b_d;
  logic                busy_q, busy_d;
  logic                err_opcode_q, err_opcode_d;
  logic                err_timeout_q, err_timeout_d;
  logic                err_overrun_q, err_overrun_d;
  logic                timeout;
`ifdef CMD_CHECKSUM_EN
  logic [7:0]          xor_q, xor_d;
  logic                err_checksum_q, err_checksum_d;
`endif

  assign shift_next = {shift_q[23:0], rx_byte};
  assign timeout = !rx_valid && (idle_q == IDLE_LAST) &&
                   (state_q != S_OPCODE) && (state_q != S_HOLD);

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    shift_d       = shift_q;
    a_pend_d      = a_pend_q;
    op_pend_d     = op_pend_q;
    cmd_valid_d   = cmd_valid_q;
    cmd_opcode_d  = cmd_opcode_q;
    cmd_a_d       = cmd_a_q;
    cmd_b_d       = cmd_b_q;
    err_opcode_d  = 1'b0;
    err_timeout_d = 1'b0;
    err_overrun_d = 1'b0;
`ifdef CMD_CHECKSUM_EN
    xor_d          = xor_q;
    err_checksum_d = 1'b0;
`endif
    idle_d = (rx_valid || state_q == S_OPCODE || state_q == S_HOLD) ? '0 : idle_q + CNT_BITS'(1);

    case (state_q)
      S_OPCODE: if (rx_valid) begin
        if (rx_byte <= 8'd2) begin
          op_pend_d  = rx_byte[1:0];
          byte_cnt_d = 2'd0;
          state_d    = S_A;
`ifdef CMD_CHECKSUM_EN
          xor_d      = rx_byte;
`endif
        end else begin
          err_opcode_d = 1'b1;
        end
      end
      S_A, S_B: if (rx_valid) begin
        shift_d    = shift_next;
        byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef CMD_CHECKSUM_EN
        xor_d      = xor_q ^ rx_byte;
`endif
        if (byte_cnt_q == 2'd3) begin
          byte_cnt_d = 2'd0;
          if (state_q == S_A) begin
            a_pend_d = shift_next;
            state_d  = S_B;
          end else begin
`ifdef CMD_CHECKSUM_EN
            state_d      = S_CSUM;
`else
            cmd_opcode_d = op_pend_q;
            cmd_a_d      = a_pend_q;
            cmd_b_d      = shift_next;
            cmd_valid_d  = 1'b1;
            state_d      = S_HOLD;
`endif
          end
        end
      end
`ifdef CMD_CHECKSUM_EN
      // B stays parked in the shift register until the checksum byte arrives
      S_CSUM: if (rx_valid) begin
        if (rx_byte == xor_q) begin
          cmd_opcode_d = op_pend_q;
          cmd_a_d      = a_pend_q;
          cmd_b_d      = shift_q;
          cmd_valid_d  = 1'b1;
          state_d      = S_HOLD;
        end else begin
          err_checksum_d = 1'b1;
          state_d        = S_OPCODE;
        end
      end
`endif
      S_HOLD: begin
        if (rx_valid) err_overrun_d = 1'b1;
        if (cmd_valid_q && cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = S_OPCODE;
        end
      end
      default: state_d = S_OPCODE;
    endcase

    // timeout only fires with rx_valid low, so nothing above has advanced the frame
    if (timeout) begin
      state_d       = S_OPCODE;
      byte_cnt_d    = 2'd0;
      idle_d        = '0;
      err_timeout_d = 1'b1;
    end

    busy_d = (state_d != S_OPCODE) && (state_d != S_HOLD);
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q       <= S_OPCODE;
      byte_cnt_q    <= '0;
      shift_q       <= '0;
      a_pend_q      <= '0;
      op_pend_q     <= '0;
      idle_q        <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_opcode_q  <= '0;
      cmd_a_q       <= '0;
      cmd_b_q       <= '0;
      busy_q        <= 1'b0;
      err_opcode_q  <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      shift_q       <= shift_d;
      a_pend_q      <= a_pend_d;
      op_pend_q     <= op_pend_d;
      idle_q        <= idle_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_opcode_q  <= cmd_opcode_d;
      cmd_a_q       <= cmd_a_d;
      cmd_b_q       <= cmd_b_d;
      busy_q        <= busy_d;
      err_opcode_q  <= err_opcode_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
    end
  end

`ifdef CMD_CHECKSUM_EN
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      xor_q          <= '0;
      err_checksum_q <= 1'b0;
    end else begin
      xor_q          <= xor_d;
      err_checksum_q <= err_checksum_d;
    end
  end
  assign err_checksum = err_checksum_q;
`else
  assign err_checksum = 1'b0;
`endif

  assign cmd_valid   = cmd_valid_q;
  assign cmd_opcode  = cmd_opcode_q;
  assign cmd_a       = cmd_a_q;
  assign cmd_b       = cmd_b_q;
  assign busy        = busy_q;
  assign err_opcode  = err_opcode_q;
  assign err_timeout = err_timeout_q;
  assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Directed bench for uart_cmd_framer with TIMEOUT_CYCLES=16; inputs change and outputs are sampled on negedges.
module tb_uart_cmd_framer;
  logic        clk_100MHz = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        cmd_ready;
  logic        cmd_valid;
  logic [1:0]  cmd_opcode;
  logic [31:0] cmd_a, cmd_b;
  logic        busy, err_opcode, err_timeout, err_overrun, err_checksum;

  int n_total = 0;
  int n_pass  = 0;
  int n_eop = 0, n_eto = 0, n_eov = 0, n_ecs = 0;

  always #5 clk_100MHz = ~clk_100MHz;

  uart_cmd_framer #(.TIMEOUT_CYCLES(16), .CNT_BITS(5)) dut (
    .clk_100MHz(clk_100MHz), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_opcode(cmd_opcode),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .busy(busy), .err_opcode(err_opcode),
    .err_timeout(err_timeout), .err_overrun(err_overrun), .err_checksum(err_checksum)
  );

  // pulses are tallied with pre-edge values, one count per high cycle
  always @(posedge clk_100MHz) begin
    if (err_opcode)   n_eop++;
    if (err_timeout)  n_eto++;
    if (err_overrun)  n_eov++;
    if (err_checksum) n_ecs++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk_100MHz);
  endtask

  task automatic send_body(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    drive(op);
    for (int i = 3; i >= 0; i--) drive(a[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) drive(b[i*8 +: 8]);
  endtask

  function automatic logic [7:0] csum(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    return op ^ a[31:24] ^ a[23:16] ^ a[15:8] ^ a[7:0] ^ b[31:24] ^ b[23:16] ^ b[15:8] ^ b[7:0];
  endfunction

  task automatic send_frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    send_body(op, a, b);
`ifdef CMD_CHECKSUM_EN
    drive(csum(op, a, b));
`endif
    rx_valid = 1'b0;
  endtask

  task automatic chk_cmd(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    chk({tag, "_valid"}, 64'(cmd_valid), 64'd1);
    chk({tag, "_op"}, 64'(cmd_opcode), 64'(op));
    chk({tag, "_a"}, 64'(cmd_a), 64'(a));
    chk({tag, "_b"}, 64'(cmd_b), 64'(b));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_outs"}, {cmd_valid, cmd_opcode, busy, err_opcode, err_timeout, err_overrun, err_checksum},
        64'd0);
    chk({tag, "_ab"}, {cmd_a, cmd_b}, 64'd0);
  endtask

  initial begin
    int e0, unstable;
    reset = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; cmd_ready = 1'b1;
    repeat (3) @(negedge clk_100MHz);
    chk_zero("reset");
    reset = 1'b0;
    @(negedge clk_100MHz);

    // nominal MULTIPLY, consumer ready
    e0 = n_eop + n_eto + n_eov + n_ecs;
    send_frame(8'h02, 32'h40490FDB, 32'h3F800000);
    chk_cmd("nominal", 2'd2, 32'h40490FDB, 32'h3F800000);
    chk("nominal_busy", 64'(busy), 64'd0);
    @(negedge clk_100MHz);
    chk("nominal_fall", 64'(cmd_valid), 64'd0);
    @(negedge clk_100MHz);
    chk("nominal_noerr", 64'(n_eop + n_eto + n_eov + n_ecs - e0), 64'd0);

    // illegal opcode then ADD frame, held with backpressure
    cmd_ready = 1'b0;
    e0 = n_eop;
    drive(8'h07);
    rx_valid = 1'b0;
    chk("illegal_pulse", 64'(err_opcode), 64'd1);
    chk("illegal_idle", 64'(busy), 64'd0);
    @(negedge clk_100MHz);
    chk("illegal_pulse_end", 64'(err_opcode), 64'd0);
    send_frame(8'h00, 32'h3F800000, 32'h40000000);
    chk_cmd("add", 2'd0, 32'h3F800000, 32'h40000000);
    chk("illegal_count", 64'(n_eop - e0), 64'd1);

    unstable = 0;
    e0 = n_eov;
    for (int i = 0; i < 50; i++) begin
      if (i == 25) begin
        drive(8'hAA);
        rx_valid = 1'b0;
        chk("overrun_pulse", 64'(err_overrun), 64'd1);
      end else begin
        @(negedge clk_100MHz);
      end
      if (cmd_valid !== 1'b1 || cmd_opcode !== 2'd0 || cmd_a !== 32'h3F800000 || cmd_b !== 32'h40000000)
        unstable++;
    end
    chk("hold_stable", 64'(unstable), 64'd0);
    chk("overrun_count", 64'(n_eov - e0), 64'd1);
    cmd_ready = 1'b1;
    chk("hold_still_valid", 64'(cmd_valid), 64'd1);
    @(negedge clk_100MHz);
    chk("release_fall", 64'(cmd_valid), 64'd0);

    // timeout: abort edge lands 16 edges after the last byte
    drive(8'h01); drive(8'h41); drive(8'h20);
    rx_valid = 1'b0;
    chk("to_busy", 64'(busy), 64'd1);
    repeat (15) @(negedge clk_100MHz);
    chk("to_early", 64'(err_timeout), 64'd0);
    @(negedge clk_100MHz);
    chk("to_pulse", 64'(err_timeout), 64'd1);
    chk("to_busy_fall", 64'(busy), 64'd0);
    chk("to_cmd_kept", {cmd_valid, cmd_a}, {1'b0, 32'h3F800000});
    @(negedge clk_100MHz);
    chk("to_pulse_end", 64'(err_timeout), 64'd0);
    send_frame(8'h01, 32'h41200000, 32'hC0000000);
    chk_cmd("after_to", 2'd1, 32'h41200000, 32'hC0000000);
    @(negedge clk_100MHz);

    // byte arriving exactly on the timeout cycle wins
    e0 = n_eto;
    drive(8'h02);
    rx_valid = 1'b0;
    repeat (15) @(negedge clk_100MHz);
    drive(8'h12); drive(8'h34); drive(8'h56); drive(8'h78);
    drive(8'h9A); drive(8'hBC); drive(8'hDE); drive(8'hF0);
`ifdef CMD_CHECKSUM_EN
    drive(csum(8'h02, 32'h12345678, 32'h9ABCDEF0));
`endif
    rx_valid = 1'b0;
    chk_cmd("race", 2'd2, 32'h12345678, 32'h9ABCDEF0);
    @(negedge clk_100MHz);
    chk("race_no_to", 64'(n_eto - e0), 64'd0);

    // reset mid-frame
    drive(8'h02); drive(8'h11); drive(8'h22); drive(8'h33); drive(8'h44);
    rx_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk_zero("rst_mid");
    repeat (2) @(negedge clk_100MHz);
    reset = 1'b0;
    @(negedge clk_100MHz);
    send_frame(8'h01, 32'h3F800000, 32'h40400000);
    chk_cmd("after_rst", 2'd1, 32'h3F800000, 32'h40400000);
    @(negedge clk_100MHz);

`ifdef CMD_CHECKSUM_EN
    send_body(8'h00, 32'h3F800000, 32'h3F800000);
    drive(8'h00);
    rx_valid = 1'b0;
    chk("csum_ok", 64'(cmd_valid), 64'd1);
    @(negedge clk_100MHz);
    send_body(8'h00, 32'h3F800000, 32'h3F800000);
    drive(8'h01);
    rx_valid = 1'b0;
    chk("csum_bad_pulse", 64'(err_checksum), 64'd1);
    chk("csum_bad_valid", 64'(cmd_valid), 64'd0);
    @(negedge clk_100MHz);
    chk("csum_bad_end", {err_checksum, cmd_valid}, 64'd0);
`else
    chk("csum_off", 64'(n_ecs), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
